// File: rtl/bus_pkg.sv
// Shared bus definitions: master FSM state encodings, default watchdog limit
// and byte-lane meaning of the select bits (also used by slaves).
package bus_pkg;

  typedef enum logic [1:0] {
    BUS_MASTER_IDLE = 2'b00,
    BUS_MASTER_BUS  = 2'b01,
    BUS_MASTER_RESP = 2'b10
  } bus_master_state_e;

  localparam int BUS_TIMEOUT_DEFAULT = 255;
  localparam int BUS_DW              = 16;
  localparam int BUS_SEL_W           = 2;

  // Select bit index: LO enables dat[7:0], HI enables dat[15:8].
  typedef enum int unsigned {
    BUS_SEL_LO = 0,
    BUS_SEL_HI = 1
  } bus_sel_bit_e;

endpackage

// File: rtl/bus_watchdog.sv
// Cycle counter for the bus master: cleared on request accept, counts while
// enabled, and flags expiry when it has counted TIMEOUT cycles. Saturates.
module bus_watchdog
  import bus_pkg::*;
#(
  parameter int TIMEOUT = BUS_TIMEOUT_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int            CW    = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT);
  localparam logic [CW-1:0] ONE   = CW'(1);

  logic [CW-1:0] count_reg;

  assign expired = enable && (count_reg == LIMIT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg <= '0;
    end else if (clear) begin
      count_reg <= '0;
    end else if (enable && (count_reg != LIMIT)) begin
      count_reg <= count_reg + ONE;
    end
  end

endmodule

// File: rtl/bus_master.sv
// Single-outstanding 16-bit bus master: request port -> bus cycle -> response port.
// Optional watchdog enabled by defining BUS_MASTER_TIMEOUT_EN.
module bus_master
  import bus_pkg::*;
#(
  parameter int AW      = 16,
  parameter int TIMEOUT = BUS_TIMEOUT_DEFAULT
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  input  logic                 req_we_i,
  input  logic [AW-1:0]        req_adr_i,
  input  logic [BUS_SEL_W-1:0] req_sel_i,
  input  logic [BUS_DW-1:0]    req_dat_i,
  output logic                 rsp_valid_o,
  input  logic                 rsp_ready_i,
  output logic [BUS_DW-1:0]    rsp_dat_o,
  output logic                 rsp_err_o,
  output logic                 rsp_timeout_o,
  output logic                 cyc_o,
  output logic                 stb_o,
  output logic                 we_o,
  output logic [AW-1:0]        adr_o,
  output logic [BUS_SEL_W-1:0] sel_o,
  output logic [BUS_DW-1:0]    dat_o,
  input  logic [BUS_DW-1:0]    dat_i,
  input  logic                 ack_i,
  input  logic                 err_i
);

  bus_master_state_e state_reg, state_next;

  logic                 cyc_reg, cyc_next;
  logic                 we_reg, we_next;
  logic [AW-1:0]        adr_reg, adr_next;
  logic [BUS_SEL_W-1:0] sel_reg, sel_next;
  logic [BUS_DW-1:0]    dat_reg, dat_next;
  logic [BUS_DW-1:0]    rsp_dat_reg, rsp_dat_next;
  logic                 rsp_err_reg, rsp_err_next;
  logic                 rsp_to_reg, rsp_to_next;
  logic                 wd_clear, wd_enable, wd_expired;

`ifdef BUS_MASTER_TIMEOUT_EN
  bus_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk     (clk_i),
    .rst_n   (rst_n_i),
    .clear   (wd_clear),
    .enable  (wd_enable),
    .expired (wd_expired)
  );
`else
  logic wd_unused;
  assign wd_unused  = wd_clear ^ wd_enable ^ (TIMEOUT > 0);
  assign wd_expired = 1'b0;
`endif

  // Ready is masked by reset so it reads 0 while rst_n_i is held low.
  assign req_ready_o   = (state_reg == BUS_MASTER_IDLE) && rst_n_i;
  assign rsp_valid_o   = (state_reg == BUS_MASTER_RESP);
  assign rsp_dat_o     = rsp_dat_reg;
  assign rsp_err_o     = rsp_err_reg;
  assign rsp_timeout_o = rsp_to_reg;
  assign cyc_o         = cyc_reg;
  assign stb_o         = cyc_reg;
  assign we_o          = we_reg;
  assign adr_o         = adr_reg;
  assign sel_o         = sel_reg;
  assign dat_o         = dat_reg;

  always_comb begin
    state_next   = state_reg;
    cyc_next     = cyc_reg;
    we_next      = we_reg;
    adr_next     = adr_reg;
    sel_next     = sel_reg;
    dat_next     = dat_reg;
    rsp_dat_next = rsp_dat_reg;
    rsp_err_next = rsp_err_reg;
    rsp_to_next  = rsp_to_reg;
    wd_clear     = 1'b0;
    wd_enable    = 1'b0;

    case (state_reg)
      BUS_MASTER_IDLE: begin
        if (req_valid_i) begin
          we_next    = req_we_i;
          adr_next   = req_adr_i;
          sel_next   = req_sel_i;
          dat_next   = req_dat_i;
          cyc_next   = 1'b1;
          wd_clear   = 1'b1;
          state_next = BUS_MASTER_BUS;
        end
      end

      BUS_MASTER_BUS: begin
        wd_enable = 1'b1;
        // Error has priority over a simultaneous ack.
        if (err_i || ack_i || wd_expired) begin
          cyc_next     = 1'b0;
          we_next      = 1'b0;
          state_next   = BUS_MASTER_RESP;
          rsp_err_next = err_i || !ack_i;
          rsp_to_next  = !err_i && !ack_i;
          rsp_dat_next = (ack_i && !err_i && !we_reg) ? dat_i : '0;
        end
      end

      BUS_MASTER_RESP: begin
        if (rsp_ready_i) begin
          rsp_dat_next = '0;
          rsp_err_next = 1'b0;
          rsp_to_next  = 1'b0;
          state_next   = BUS_MASTER_IDLE;
        end
      end

      default: state_next = BUS_MASTER_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_reg   <= BUS_MASTER_IDLE;
      cyc_reg     <= 1'b0;
      we_reg      <= 1'b0;
      adr_reg     <= '0;
      sel_reg     <= '0;
      dat_reg     <= '0;
      rsp_dat_reg <= '0;
      rsp_err_reg <= 1'b0;
      rsp_to_reg  <= 1'b0;
    end else begin
      state_reg   <= state_next;
      cyc_reg     <= cyc_next;
      we_reg      <= we_next;
      adr_reg     <= adr_next;
      sel_reg     <= sel_next;
      dat_reg     <= dat_next;
      rsp_dat_reg <= rsp_dat_next;
      rsp_err_reg <= rsp_err_next;
      rsp_to_reg  <= rsp_to_next;
    end
  end

endmodule

// File: doc/bus_master.md
# bus_master

Single-outstanding bus master that turns client requests (from microcode memory-access logic) into 16-bit bus cycles on the shared slave bus, e.g. toward the ROM/RAM slave with 1-cycle registered ack/err. Latches address, data, byte selects and direction, holds `cyc_o`/`stb_o` until `ack_i` or `err_i`, and returns read data and status through a ready/valid response port. An optional watchdog ends cycles that no slave acknowledges.

## Interface
- `AW`, 16: bus address width.
- `TIMEOUT`, 255: max cycles with `stb_o` high before forced error (1..65535).
- `clk_i` input 1: clock, all state on rising edge.
- `rst_n_i` input 1: asynchronous, active-low reset.
- `req_valid_i` input 1: client request present.
- `req_ready_o` output 1: master can accept a request.
- `req_we_i` input 1: 1 = write, 0 = read.
- `req_adr_i` input AW: word address.
- `req_sel_i` input 2: byte selects, bit 1 = [15:8], bit 0 = [7:0].
- `req_dat_i` input 16: write data.
- `rsp_valid_o` output 1: response present.
- `rsp_ready_i` input 1: client takes response.
- `rsp_dat_o` output 16: read data (0 for writes and errors).
- `rsp_err_o` output 1: cycle ended in slave error or timeout.
- `rsp_timeout_o` output 1: error came from watchdog.
- `cyc_o`, `stb_o`, `we_o` output 1 each; `adr_o` output AW; `sel_o` output 2; `dat_o` output 16: bus master signals.
- `dat_i` input 16; `ack_i`, `err_i` input 1 each: bus slave returns.

## Operation
- States: IDLE, BUS, RESP. Reset → IDLE.
- IDLE: `req_ready_o`=1. On `req_valid_i`: latch we/adr/sel/dat into bus outputs, set `cyc_o`=`stb_o`=1, clear watchdog, → BUS.
- BUS: `req_ready_o`=0, bus outputs held stable.
  - `err_i`: `rsp_err_o`=1, `rsp_dat_o`=0 → RESP. `err_i` wins when both `ack_i` and `err_i` are high.
  - `ack_i` alone: `rsp_dat_o`=`dat_i` for reads, 0 for writes; `rsp_err_o`=0 → RESP.
  - On exit, `cyc_o`, `stb_o`, `we_o` drop to 0 in the same edge.
  - Watchdog reaches `TIMEOUT` with no ack/err: `rsp_err_o`=`rsp_timeout_o`=1 → RESP.
- RESP: `rsp_valid_o`=1, response held until `rsp_ready_i`, then → IDLE. No bypass: a new request is accepted no earlier than the cycle after RESP exits. This guarantees at least one `stb_o`-low cycle between bus cycles, which is the minimum the slave needs to return to idle.
- `ack_i`/`err_i` outside BUS are ignored.
- Reset mid-cycle: all outputs go to 0 immediately; any in-flight request is dropped and no response is produced.

## Timing
- Reset values: `req_ready_o`=1 (once `rst_n_i` is high), all other outputs 0.
- Request accepted at edge N → `stb_o` high after N. Slave with 1-cycle registered ack → `ack_i` high after N+1, sampled at N+2 → `rsp_valid_o` high after N+2.
- With `rsp_ready_i` tied high, back-to-back throughput is 1 transfer per 4 cycles.
- Watchdog: counts cycles in BUS. Timeout fires on the edge where count = `TIMEOUT`, so `stb_o` stays high for exactly `TIMEOUT`+1 cycles.
- Counter width is $clog2(TIMEOUT+1) and never wraps.

## Configuration
- `BUS_MASTER_TIMEOUT_EN` defined: watchdog present as described. `rsp_timeout_o` is live.
- Not defined: no counter. BUS waits indefinitely for `ack_i`/`err_i`. `rsp_timeout_o` is tied 0. `TIMEOUT` is ignored.

## Structure
- `bus_pkg` holds:
  - state encodings `BUS_MASTER_IDLE`=2'b00, `BUS_MASTER_BUS`=2'b01, `BUS_MASTER_RESP`=2'b10;
  - the default `TIMEOUT` constant;
  - the sel bit meanings, shared with slaves.
- Sub-module `bus_watchdog` (clear, enable, `TIMEOUT` parameter → `expired` pulse), instantiated only under `BUS_MASTER_TIMEOUT_EN`.

## Test plan
- Read, adr=16'o177034, slave returns 16'hFFFF with 1-cycle ack → `rsp_valid_o` 2 cycles after accept, `rsp_dat_o`=16'hFFFF, `rsp_err_o`=0; `stb_o` high exactly 2 cycles.
- Write, sel=2'b01, dat=16'hA55A → `dat_o`=16'hA55A, `sel_o`=01, `we_o`=1 stable until ack; `rsp_dat_o`=0, `rsp_err_o`=0.
- Write to read-only slave (slave asserts `err_i`) → `rsp_err_o`=1, `rsp_timeout_o`=0, `rsp_dat_o`=0.
- `ack_i` and `err_i` asserted together → error response.
- Stray `ack_i` in IDLE → ignored, no response.
- No slave response with `TIMEOUT`=8 and macro defined → `stb_o` high 9 cycles, then `rsp_err_o`=`rsp_timeout_o`=1. Macro undefined → still waiting after 1000 cycles.
- `rsp_ready_i` held low 5 cycles → response held stable and `req_ready_o`=0 throughout. Pulse `rst_n_i` low mid-BUS → `cyc_o`/`stb_o` go 0 asynchronously; no `rsp_valid_o` after reset release.
